// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 4-digit multiplexed 7-segment display scheduler.
//   - DIGx      : active-low one-hot anode codes (DIG3 = leftmost digit)
//   - SEG_BLANK : digit code the segment decoder renders as blank
//   - state_e   : display ownership state
//   - nibble_sel: picks the BCD nibble shown for a given anode code
//   - lz_blank  : leading-zero suppression (used when SEG_LZ_BLANK_EN is set)
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [3:0] DIG3      = 4'b0111;
    localparam logic [3:0] DIG2      = 4'b1011;
    localparam logic [3:0] DIG1      = 4'b1101;
    localparam logic [3:0] DIG0      = 4'b1110;
    localparam logic [3:0] SEG_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    // Nibble of a packed BCD word that belongs on the given anode.
    function automatic logic [3:0] nibble_sel(input logic [15:0] word,
                                              input logic [3:0]  digit);
        logic [3:0] nib;
        case (digit)
            DIG3:    nib = word[15:12];
            DIG2:    nib = word[11:8];
            DIG1:    nib = word[7:4];
            DIG0:    nib = word[3:0];
            default: nib = SEG_BLANK;
        endcase
        return nib;
    endfunction

    // Blank leading zeros from the left; digit 0 always stays visible.
    function automatic logic [15:0] lz_blank(input logic [15:0] word);
        logic z3;
        logic z2;
        logic z1;
        z3 = (word[15:12] == 4'h0);
        z2 = z3 && (word[11:8] == 4'h0);
        z1 = z2 && (word[7:4] == 4'h0);
        return {z3 ? SEG_BLANK : word[15:12],
                z2 ? SEG_BLANK : word[11:8],
                z1 ? SEG_BLANK : word[7:4],
                word[3:0]};
    endfunction

endpackage

// File: rtl/seg_display_sched_if.sv
// -----------------------------------------------------------------------------
// seg_display_sched_if
// Requester and display-side signals of the display scheduler.
//   req_a/data_a   : requester A (priority) and its BCD word
//   req_b/data_b   : requester B (minimum hold) and its BCD word
//   grant_a/grant_b: current frame owner
//   frame_tick     : one-cycle pulse at each frame boundary
//   DIGIT          : active-low one-hot anode select
//   value          : digit code for the segment decoder (4'hF = blank)
// master = requesters / observer side, slave = the scheduler.
// -----------------------------------------------------------------------------
interface seg_display_sched_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        grant_a;
    logic        grant_b;
    logic        frame_tick;
    logic [3:0]  DIGIT;
    logic [3:0]  value;

    modport master (
        output req_a, data_a, req_b, data_b,
        input  grant_a, grant_b, frame_tick, DIGIT, value
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output grant_a, grant_b, frame_tick, DIGIT, value
    );
endinterface

// File: rtl/seg_scan_prescaler.sv
// -----------------------------------------------------------------------------
// seg_scan_prescaler
// Free-running divider producing a one-cycle step every SCAN_DIV clocks.
//   clk  : system clock
//   rst  : asynchronous active-high reset (counter -> 0)
//   step : high in the cycle where the count equals SCAN_DIV-1
// SCAN_DIV = 1 yields a step on every cycle.
// -----------------------------------------------------------------------------
module seg_scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic step
);

    localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          step_s;

    assign step_s = (cnt_r == LAST);
    assign step   = step_s;

    // Scan counter: wraps to zero on the step cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (step_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1'b1);
        end
    end

endmodule

// File: rtl/seg_display_sched.sv
// -----------------------------------------------------------------------------
// seg_display_sched
// Arbitrates two BCD requesters for a shared 4-digit active-low common-anode
// display and scans the owner's word onto the anode select / digit code.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : seg_display_sched_if.slave (requests, data, grants, frame_tick,
//         DIGIT, value)
// Parameters: SCAN_DIV clocks per digit step, MIN_HOLD frames B keeps the
// display once granted while req_b stays high.
// Build option: define SEG_LZ_BLANK_EN to blank leading zeros of the word
// latched at each frame boundary.
// Ownership and the displayed word only change at a frame boundary (the step
// where DIGIT wraps 1110 -> 0111), so a frame is never torn.
// -----------------------------------------------------------------------------
module seg_display_sched
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int MIN_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg_display_sched_if.slave  bus
);

    localparam int            HW       = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD - 1);

    state_e        state_r,     state_nx;
    logic [HW-1:0] hold_r,      hold_nx;
    logic [15:0]   frame_buf_r, frame_buf_nx;
    logic [3:0]    digit_r,     digit_nx;
    logic [3:0]    value_r,     value_nx;
    logic          grant_a_r;
    logic          grant_b_r;
    logic          frame_tick_r;
    logic          step_s;
    logic          boundary_s;
    logic [15:0]   owner_word_s;

    seg_scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .step (step_s)
    );

    assign boundary_s = step_s && (digit_r == DIG0);

    // Next-state: digit rotation, arbitration at boundaries, code selection.
    always_comb begin
        state_nx     = state_r;
        hold_nx      = hold_r;
        frame_buf_nx = frame_buf_r;
        digit_nx     = digit_r;
        value_nx     = value_r;
        owner_word_s = 16'hFFFF;

        if (step_s) begin
            case (digit_r)
                DIG0:    digit_nx = DIG3;
                DIG3:    digit_nx = DIG2;
                DIG2:    digit_nx = DIG1;
                DIG1:    digit_nx = DIG0;
                default: digit_nx = DIG0;   // recover from any illegal code
            endcase

            if (boundary_s) begin
                // B's hold window outranks A; otherwise A has priority.
                if ((state_r == OWN_B) && bus.req_b && (hold_r < HOLD_MAX)) begin
                    state_nx = OWN_B;
                    hold_nx  = hold_r + HW'(1'b1);
                end else if (bus.req_a) begin
                    state_nx = OWN_A;
                    hold_nx  = '0;
                end else if (bus.req_b) begin
                    state_nx = OWN_B;
                    hold_nx  = (state_r == OWN_B) ? HOLD_MAX : '0;
                end else begin
                    state_nx = IDLE;
                    hold_nx  = '0;
                end

                case (state_nx)
                    OWN_A:   owner_word_s = bus.data_a;
                    OWN_B:   owner_word_s = bus.data_b;
                    default: owner_word_s = 16'hFFFF;
                endcase

`ifdef SEG_LZ_BLANK_EN
                frame_buf_nx = lz_blank(owner_word_s);
`else
                frame_buf_nx = owner_word_s;
`endif
                // The new frame starts on DIG3, so show the new word's top nibble.
                value_nx = frame_buf_nx[15:12];
            end else begin
                value_nx = nibble_sel(frame_buf_r, digit_nx);
            end
        end else begin
            digit_nx = digit_r;
        end
    end

    // State and display registers; DIGIT and value move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            hold_r       <= '0;
            frame_buf_r  <= 16'hFFFF;
            digit_r      <= DIG0;
            value_r      <= SEG_BLANK;
            grant_a_r    <= 1'b0;
            grant_b_r    <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            state_r      <= state_nx;
            hold_r       <= hold_nx;
            frame_buf_r  <= frame_buf_nx;
            digit_r      <= digit_nx;
            value_r      <= value_nx;
            grant_a_r    <= (state_nx == OWN_A);
            grant_b_r    <= (state_nx == OWN_B);
            frame_tick_r <= boundary_s;
        end
    end

    assign bus.DIGIT      = digit_r;
    assign bus.value      = value_r;
    assign bus.grant_a    = grant_a_r;
    assign bus.grant_b    = grant_b_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_display_sched.sv
// -----------------------------------------------------------------------------
// tb_seg_display_sched
// Scoreboard bench for seg_display_sched with SCAN_DIV=4, MIN_HOLD=2.
// The driver pushes one expected record per digit step; the monitor pops a
// record at each step and checks every clock of it on the falling edge.
// Expected words honour SEG_LZ_BLANK_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_seg_display_sched;
    import seg_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int MIN_HOLD = 2;

    typedef struct {
        logic [3:0] digit;
        logic [3:0] value;
        logic       ga;
        logic       gb;
        logic       tk;
        int         ncyc;
        int         tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tag_n = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seg_display_sched_if bus();

    seg_display_sched #(
        .SCAN_DIV (SCAN_DIV),
        .MIN_HOLD (MIN_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected display word for a raw BCD word.
    function automatic logic [15:0] disp(input logic [15:0] w);
        logic [15:0] r;
        r = w;
`ifdef SEG_LZ_BLANK_EN
        if (r[15:12] == 4'h0) begin
            r[15:12] = 4'hF;
            if (r[11:8] == 4'h0) begin
                r[11:8] = 4'hF;
                if (r[7:4] == 4'h0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    // Queue one step's expectation, then let it play out for n clocks.
    task automatic push(input logic [3:0] d, input logic [3:0] v,
                        input logic ga, input logic gb, input logic tk, input int n);
        exp_t e;
        e.digit = d; e.value = v; e.ga = ga; e.gb = gb; e.tk = tk;
        e.ncyc = n; e.tag = tag_n;
        tag_n++;
        exp_q.push_back(e);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] w, input logic ga, input logic gb);
        push(DIG3, w[15:12], ga, gb, 1'b1, 4);
        push(DIG2, w[11:8],  ga, gb, 1'b0, 4);
        push(DIG1, w[7:4],   ga, gb, 1'b0, 4);
        push(DIG0, w[3:0],   ga, gb, 1'b0, 4);
    endtask

    // Frame with new request/data values applied after its second digit.
    task automatic frame_mid(input logic [15:0] w, input logic ga, input logic gb,
                             input logic ra, input logic [15:0] da,
                             input logic rb, input logic [15:0] db);
        push(DIG3, w[15:12], ga, gb, 1'b1, 4);
        push(DIG2, w[11:8],  ga, gb, 1'b0, 4);
        bus.req_a = ra; bus.data_a = da; bus.req_b = rb; bus.data_b = db;
        push(DIG1, w[7:4],   ga, gb, 1'b0, 4);
        push(DIG0, w[3:0],   ga, gb, 1'b0, 4);
    endtask

    task automatic check_now(input string name, input logic [10:0] got, input logic [10:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: DIGIT/value/ga/gb/tick got %b/%h/%b/%b/%b, want %b/%h/%b/%b/%b",
                     name, got[10:7], got[6:3], got[2], got[1], got[0],
                     want[10:7], want[6:3], want[2], want[1], want[0]);
        end
    endtask

    // Monitor: one record per digit step, every cycle of the step checked.
    initial begin : monitor
        exp_t cur;
        int   left;
        int   c;
        logic [10:0] got;
        logic [10:0] want;
        left = 0;
        c    = 0;
        forever begin
            @(negedge clk);
            if (left == 0 && exp_q.size() > 0) begin
                cur  = exp_q.pop_front();
                left = cur.ncyc;
                c    = 0;
            end
            if (left > 0) begin
                got  = {bus.DIGIT, bus.value, bus.grant_a, bus.grant_b, bus.frame_tick};
                want = {cur.digit, cur.value, cur.ga, cur.gb, (cur.tk && c == 0)};
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL step%0d cyc%0d: DIGIT/value/ga/gb/tick got %b/%h/%b/%b/%b, want %b/%h/%b/%b/%b",
                             cur.tag, c, got[10:7], got[6:3], got[2], got[1], got[0],
                             want[10:7], want[6:3], want[2], want[1], want[0]);
                end
                left--;
                c++;
            end
        end
    end

    // Hard bound on run time.
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end, want summary");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin : driver
        rst = 1'b1;
        bus.req_a = 1'b0; bus.data_a = 16'h0000;
        bus.req_b = 1'b0; bus.data_b = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        push(DIG0, 4'hF, 1'b0, 1'b0, 1'b0, 3);          // reset state until first step

        frame(16'hFFFF, 1'b0, 1'b0);                     // idle frames, blank
        frame(16'hFFFF, 1'b0, 1'b0);

        bus.req_a = 1'b1; bus.data_a = 16'h1234;
        frame(disp(16'h1234), 1'b1, 1'b0);
        frame_mid(disp(16'h1234), 1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 16'h0000);
        // A drops and B raises mid-frame: A keeps this frame.
        frame_mid(disp(16'h9999), 1'b1, 1'b0, 1'b0, 16'h9999, 1'b1, 16'h5678);
        // A returns during B's first frame: B still gets its second frame.
        frame_mid(disp(16'h5678), 1'b0, 1'b1, 1'b1, 16'h9999, 1'b1, 16'h5678);
        frame(disp(16'h5678), 1'b0, 1'b1);
        frame(disp(16'h9999), 1'b1, 1'b0);

        bus.req_a = 1'b0;                                // B alone: entry, hold, saturate
        frame(disp(16'h5678), 1'b0, 1'b1);
        frame(disp(16'h5678), 1'b0, 1'b1);
        frame(disp(16'h5678), 1'b0, 1'b1);

        bus.req_b = 1'b0; bus.req_a = 1'b1; bus.data_a = 16'h0042;
        frame(disp(16'h0042), 1'b1, 1'b0);
        bus.data_a = 16'h0000;
        frame(disp(16'h0000), 1'b1, 1'b0);
        bus.data_a = 16'h0040;
        frame(disp(16'h0040), 1'b1, 1'b0);
        bus.data_a = 16'hA0B9;                           // non-BCD nibbles pass through
        frame(disp(16'hA0B9), 1'b1, 1'b0);
        bus.req_a = 1'b0;
        frame(16'hFFFF, 1'b0, 1'b0);

        // Asynchronous reset while digit 1101 is shown.
        bus.req_a = 1'b1; bus.data_a = 16'h1234;
        push(DIG3, 4'h1, 1'b1, 1'b0, 1'b1, 4);
        push(DIG2, 4'h2, 1'b1, 1'b0, 1'b0, 4);
        push(DIG1, 4'h3, 1'b1, 1'b0, 1'b0, 2);
        #2;
        rst = 1'b1;
        #1;
        check_now("async_reset", {bus.DIGIT, bus.value, bus.grant_a, bus.grant_b, bus.frame_tick},
                  {4'b1110, 4'hF, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        check_now("reset_held", {bus.DIGIT, bus.value, bus.grant_a, bus.grant_b, bus.frame_tick},
                  {4'b1110, 4'hF, 1'b0, 1'b0, 1'b0});
        #1;
        rst = 1'b0;
        push(DIG0, 4'hF, 1'b0, 1'b0, 1'b0, 3);
        frame(disp(16'h1234), 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
